uart_ahb_arb: RTL

Two-requester arbiter and access sequencer in front of uart_top's AHB slave port. It grants the slave to one requester at a time using round-robin and drives uart_top's hsel/hwrite/haddr/hwdata access sequence. Buffer reads are wrapped automatically in the is_scanf set/clear protocol. It sits between the core's printf/scanf path (requester 0) and the debug path (requester 1) and a single uart_top instance.

---
 rtl/uart_ahb_arb_if.sv | 29 ++
 rtl/uart_ahb_arb.sv | 100 ++++++++++
 2 files changed

// File: rtl/uart_ahb_arb_if.sv
// uart_ahb_arb_if: requester-side and uart_top-side signals of uart_ahb_arb.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
interface uart_ahb_arb_if;
  logic m0_req, m1_req, m0_we, m1_we;
  logic [`AHB_ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [`AHB_DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic m0_done, m1_done, m0_err, m1_err;
  logic [`AHB_DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic hsel, hwrite, hready, hresp;
  logic [`AHB_ADDR_WIDTH-1:0] haddr;
  logic [`AHB_DATA_WIDTH-1:0] hwdata, hrdata;
  modport slave (
    input m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
    output hsel, hwrite, haddr, hwdata,
    input hready, hresp, hrdata
  );
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
    input hsel, hwrite, haddr, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/uart_ahb_arb.sv
// uart_ahb_arb: round-robin arbiter/sequencer for uart_top's AHB port; buffer reads are scanf-wrapped.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
module uart_ahb_arb #(
  parameter logic [`AHB_ADDR_WIDTH-1:0] SCANF_ADDR = 32'h70F0_F0F0,
  parameter logic [`AHB_ADDR_WIDTH-1:0] BUF_ADDR   = 32'h30F0_F0F0,
  parameter logic [`AHB_DATA_WIDTH-1:0] SCANF_SET  = 32'h0000_007F,
  parameter logic [`AHB_DATA_WIDTH-1:0] SCANF_CLR  = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rstn,
  uart_ahb_arb_if.slave bus
);
  localparam int AW = `AHB_ADDR_WIDTH;
  localparam int DW = `AHB_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, SEL, ADDR, DATA, WAIT, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic g, gn, ptr, we, err_acc, a_we, bufrd, last, fin, fail, to;
  logic [1:0] sub;
  logic [AW-1:0] addr, a_addr;
  logic [DW-1:0] wdata, a_data, rbuf, cap, rdata0, rdata1;
  assign gn = bus.m0_req && bus.m1_req ? ptr : bus.m1_req;
  assign bufrd = !we && addr == BUF_ADDR;
  assign last = sub == 2'd2 || !bufrd;
  assign a_we = sub == 2'd1 ? we : 1'b1;
  assign a_addr = sub == 2'd1 ? addr : SCANF_ADDR;
  assign a_data = sub == 2'd1 ? wdata : sub == 2'd0 ? SCANF_SET : SCANF_CLR;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign to = state == WAIT && !bus.hready && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 16'd1 : 16'd0;
`else
  assign to = 1'b0;
`endif
  assign fin = state == WAIT && (bus.hready || to);
  assign fail = to || bus.hresp;
  assign cap = to ? '0 : bus.hrdata;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.m0_req || bus.m1_req ? SEL : IDLE;
      SEL: state_nx = ADDR;
      ADDR: state_nx = a_we ? DATA : WAIT;
      DATA: state_nx = WAIT;
      WAIT: state_nx = fin ? (last ? DONE : NEXT) : WAIT;
      NEXT: state_nx = SEL;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.hsel = state == SEL;
  assign bus.hwrite = state == SEL && a_we;
  assign bus.haddr = state == ADDR ? a_addr : '0;
  assign bus.hwdata = state == DATA ? a_data : '0;
  assign bus.m0_done = state == DONE && !g;
  assign bus.m1_done = state == DONE && g;
  assign bus.m0_err = bus.m0_done && err_acc;
  assign bus.m1_err = bus.m1_done && err_acc;
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      g <= 1'b0;
      ptr <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      sub <= '0;
      err_acc <= 1'b0;
      rbuf <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        g <= gn;
        we <= gn ? bus.m1_we : bus.m0_we;
        addr <= gn ? bus.m1_addr : bus.m0_addr;
        wdata <= gn ? bus.m1_wdata : bus.m0_wdata;
        err_acc <= 1'b0;
        sub <= {1'b0, !(gn ? !bus.m1_we && bus.m1_addr == BUF_ADDR : !bus.m0_we && bus.m0_addr == BUF_ADDR)};
      end
      if (state == NEXT) sub <= sub + 2'd1;
      if (fin) begin
        err_acc <= err_acc || fail;
        if (sub == 2'd1) rbuf <= cap;
      end
      if (fin && last && g) rdata1 <= sub == 2'd1 ? cap : rbuf;
      if (fin && last && !g) rdata0 <= sub == 2'd1 ? cap : rbuf;
      if (state == DONE) ptr <= !g;
    end
endmodule
